// File: rtl/sparse_vec_pack_pkg.sv
// Shared sizing for the sparse-vector datapath: per-set dimensions, sparse-entry
// field widths and the packer FSM state type.
package sparse_vec_pack_pkg;

    localparam int unsigned L1_VEC_SIZE_BYTES   = 126;
    localparam int unsigned L2_VEC_SIZE_BYTES   = 193;
    localparam int unsigned L3_VEC_SIZE_BYTES   = 278;
    localparam int unsigned TEST_VEC_SIZE_BYTES = 8;

    localparam int unsigned L1_VEC_WEIGHT   = 79;
    localparam int unsigned L2_VEC_WEIGHT   = 120;
    localparam int unsigned L3_VEC_WEIGHT   = 150;
    localparam int unsigned TEST_VEC_WEIGHT = 3;

    localparam int unsigned N_GF_DEFAULT = 8;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StScan,
        StPad,
        StDone
    } state_e;

    // Keeps single-entry dimensions from collapsing to zero-width buses.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned sp_pos_width(input int unsigned vec_size_bytes);
        return clog2_min1(vec_size_bytes);
    endfunction

    function automatic int unsigned sp_entry_width(input int unsigned vec_size_bytes);
        return sp_pos_width(vec_size_bytes) + 8;
    endfunction

    // One extra bit so the slot count can reach VEC_WEIGHT itself.
    function automatic int unsigned sp_addr_width(input int unsigned vec_weight);
        return $clog2(vec_weight) + 1;
    endfunction

endpackage

// File: rtl/sparse_vec_pack_lane_prio_enc.sv
// Lowest-set-lane priority encoder over a byte-lane mask (combinational).
module lane_prio_enc
    import sparse_vec_pack_pkg::*;
#(
    parameter int unsigned N_GF = 8
) (
    input  logic [N_GF-1:0]             mask_i,
    output logic [clog2_min1(N_GF)-1:0] idx_o,
    output logic                        valid_o
);

    localparam int unsigned IW = clog2_min1(N_GF);

    // Descending walk so the lowest set lane is the last one to win.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = N_GF - 1; k >= 0; k--) begin
            if (mask_i[k]) begin
                idx_o   = IW'(k);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sparse_vec_pack.sv
// Scans a dense GF(256) vector word by word and writes its nonzero bytes as
// {position, value} entries into a fixed-weight sparse table, zero-padding the tail.
module sparse_vec_pack
    import sparse_vec_pack_pkg::*;
#(
    parameter string       PARAMETER_SET  = "L3",
    parameter int unsigned VEC_SIZE_BYTES =
        (PARAMETER_SET == "L1") ? L1_VEC_SIZE_BYTES :
        (PARAMETER_SET == "L2") ? L2_VEC_SIZE_BYTES :
        (PARAMETER_SET == "L3") ? L3_VEC_SIZE_BYTES : TEST_VEC_SIZE_BYTES,
    parameter int unsigned VEC_WEIGHT     =
        (PARAMETER_SET == "L1") ? L1_VEC_WEIGHT :
        (PARAMETER_SET == "L2") ? L2_VEC_WEIGHT :
        (PARAMETER_SET == "L3") ? L3_VEC_WEIGHT : TEST_VEC_WEIGHT,
    parameter int unsigned N_GF           = N_GF_DEFAULT,
    parameter int unsigned NWORDS         = (VEC_SIZE_BYTES + N_GF - 1) / N_GF
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_start,
    output logic                                      o_dense_rd,
    output logic [clog2_min1(NWORDS)-1:0]             o_dense_addr,
    input  logic [N_GF*8-1:0]                         i_dense,
    output logic                                      o_sp_wen,
    output logic [sp_addr_width(VEC_WEIGHT)-1:0]      o_sp_addr,
    output logic [sp_entry_width(VEC_SIZE_BYTES)-1:0] o_sp_data,
    output logic [sp_addr_width(VEC_WEIGHT)-1:0]      o_weight,
    output logic                                      o_overflow,
    output logic                                      o_done
);

    localparam int unsigned PROC_SIZE = N_GF * 8;
    localparam int unsigned AW        = clog2_min1(NWORDS);
    localparam int unsigned WW        = sp_addr_width(VEC_WEIGHT);
    localparam int unsigned PW        = sp_pos_width(VEC_SIZE_BYTES);
    localparam int unsigned IW        = clog2_min1(N_GF);

    state_e                 state_q, state_d;
    logic [AW-1:0]          word_cnt_q, word_cnt_d;
    logic [PROC_SIZE-1:0]   word_q, word_d;
    logic [N_GF-1:0]        mask_q, mask_d;
    logic [WW-1:0]          weight_q, weight_d;
    logic [WW-1:0]          pad_q, pad_d;
    logic                   ovf_q, ovf_d;

    logic [31:0]            base_pos;
    logic [N_GF-1:0]        mask_in;
    logic [IW-1:0]          lane_idx;
    logic                   lane_valid;
    logic [N_GF-1:0]        lane_oh;
    logic [N_GF-1:0]        mask_clr;
    logic [7:0]             lane_byte;
    logic [PW-1:0]          lane_pos;

    lane_prio_enc #(
        .N_GF (N_GF)
    ) u_lane_prio_enc (
        .mask_i  (mask_q),
        .idx_o   (lane_idx),
        .valid_o (lane_valid)
    );

    assign base_pos = 32'(word_cnt_q) * N_GF;

    // Lanes past the end of the vector in the final word never enter the mask.
    always_comb begin
        mask_in = '0;
        for (int k = 0; k < N_GF; k++) begin
            if ((i_dense[PROC_SIZE-1-8*k -: 8] != 8'h00) &&
                (base_pos + 32'(k) < VEC_SIZE_BYTES)) begin
                mask_in[k] = 1'b1;
            end
        end
    end

    always_comb begin
        lane_byte = '0;
        lane_oh   = '0;
        for (int k = 0; k < N_GF; k++) begin
            if (lane_idx == IW'(k)) begin
                lane_byte  = word_q[PROC_SIZE-1-8*k -: 8];
                lane_oh[k] = 1'b1;
            end
        end
    end

    assign mask_clr = mask_q & ~lane_oh;
    assign lane_pos = PW'(base_pos + 32'(lane_idx));

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        word_d       = word_q;
        mask_d       = mask_q;
        weight_d     = weight_q;
        pad_d        = pad_q;
        ovf_d        = ovf_q;
        o_dense_rd   = 1'b0;
        o_dense_addr = '0;
        o_sp_wen     = 1'b0;
        o_sp_addr    = '0;
        o_sp_data    = '0;
        o_done       = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d    = StFetch;
                    weight_d   = '0;
                    ovf_d      = 1'b0;
                    word_cnt_d = '0;
                end
            end
            StFetch: begin
                o_dense_rd   = 1'b1;
                o_dense_addr = word_cnt_q;
                state_d      = StWait;
            end
            StWait: begin
                word_d  = i_dense;
                mask_d  = mask_in;
                state_d = StScan;
            end
            StScan: begin
                if (lane_valid) begin
                    mask_d = mask_clr;
                    if (weight_q == WW'(VEC_WEIGHT)) begin
                        ovf_d = 1'b1;
                    end else begin
                        o_sp_wen  = 1'b1;
                        o_sp_addr = weight_q;
                        o_sp_data = {lane_pos, lane_byte};
                        weight_d  = weight_q + WW'(1);
                    end
                end
                // Leave on the cycle that consumes the last lane, not one later.
                if (!lane_valid || (mask_clr == '0)) begin
                    if (word_cnt_q < AW'(NWORDS - 1)) begin
                        word_cnt_d = word_cnt_q + AW'(1);
                        state_d    = StFetch;
                    end else begin
                        pad_d   = weight_d;
                        state_d = StPad;
                    end
                end
            end
            StPad: begin
                if (pad_q < WW'(VEC_WEIGHT)) begin
                    o_sp_wen  = 1'b1;
                    o_sp_addr = pad_q;
                    pad_d     = pad_q + WW'(1);
                    if (pad_q == WW'(VEC_WEIGHT - 1)) begin
                        state_d = StDone;
                    end
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                o_done  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            word_q     <= '0;
            mask_q     <= '0;
            weight_q   <= '0;
            pad_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            word_q     <= word_d;
            mask_q     <= mask_d;
            weight_q   <= weight_d;
            pad_q      <= pad_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_weight   = weight_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_sparse_vec_pack.sv
// Scoreboard bench: dut_a uses the test set (8 bytes, weight 3); dut_b is 12 bytes, weight 4.
module tb_sparse_vec_pack;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    always #5 clk = ~clk;

    logic        rd_a, wen_a, ovf_a, done_a;
    logic [0:0]  addr_a;
    logic [63:0] dense_a, mem_a;
    logic [2:0]  spaddr_a, weight_a;
    logic [10:0] spdata_a;

    logic        rd_b, wen_b, ovf_b, done_b;
    logic [0:0]  addr_b;
    logic [63:0] dense_b;
    logic [63:0] mem_b [2];
    logic [2:0]  spaddr_b, weight_b;
    logic [11:0] spdata_b;

    sparse_vec_pack #(
        .PARAMETER_SET ("TEST")
    ) dut_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start_a),
        .o_dense_rd   (rd_a),
        .o_dense_addr (addr_a),
        .i_dense      (dense_a),
        .o_sp_wen     (wen_a),
        .o_sp_addr    (spaddr_a),
        .o_sp_data    (spdata_a),
        .o_weight     (weight_a),
        .o_overflow   (ovf_a),
        .o_done       (done_a)
    );

    sparse_vec_pack #(
        .PARAMETER_SET  ("TEST"),
        .VEC_SIZE_BYTES (12),
        .VEC_WEIGHT     (4)
    ) dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start_b),
        .o_dense_rd   (rd_b),
        .o_dense_addr (addr_b),
        .i_dense      (dense_b),
        .o_sp_wen     (wen_b),
        .o_sp_addr    (spaddr_b),
        .o_sp_data    (spdata_b),
        .o_weight     (weight_b),
        .o_overflow   (ovf_b),
        .o_done       (done_b)
    );

    // Dense memories: one cycle of read latency.
    always @(posedge clk) begin
        dense_a <= mem_a;
        dense_b <= mem_b[addr_b];
    end

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int weight; int ovf; int lat; } done_t;

    wr_t   exp_wr_a[$], exp_wr_b[$];
    done_t exp_dn_a[$], exp_dn_b[$];
    wr_t   ew_a, ew_b;
    done_t ed_a, ed_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc_a = 0, start_cyc_b = 0;
    int done_cnt_a  = 0, done_cnt_b  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic void push_wr_a(input int slot, input int pos, input int val);
        exp_wr_a.push_back('{addr: slot, data: (pos << 8) | val});
    endfunction

    function automatic void push_wr_b(input int slot, input int pos, input int val);
        exp_wr_b.push_back('{addr: slot, data: (pos << 8) | val});
    endfunction

    always @(negedge clk) begin
        if (wen_a) begin
            check("a_rd_wen_exclusive", 32'(rd_a), 0);
            if (exp_wr_a.size() == 0) begin
                n_checks++;
                $display("FAIL a_unexpected_write: got slot %0d data %0h, required no write",
                         spaddr_a, spdata_a);
            end else begin
                ew_a = exp_wr_a.pop_front();
                check("a_sp_addr", 32'(spaddr_a), ew_a.addr);
                check("a_sp_data", 32'(spdata_a), ew_a.data);
            end
        end
        if (rd_a) check("a_dense_addr", 32'(addr_a), 0);
        if (done_a) begin
            done_cnt_a++;
            if (exp_dn_a.size() == 0) begin
                n_checks++;
                $display("FAIL a_unexpected_done: got o_done=1, required 0");
            end else begin
                ed_a = exp_dn_a.pop_front();
                check("a_weight", 32'(weight_a), ed_a.weight);
                check("a_overflow", 32'(ovf_a), ed_a.ovf);
                check("a_done_latency", cyc - start_cyc_a, ed_a.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (wen_b) begin
            check("b_rd_wen_exclusive", 32'(rd_b), 0);
            if (exp_wr_b.size() == 0) begin
                n_checks++;
                $display("FAIL b_unexpected_write: got slot %0d data %0h, required no write",
                         spaddr_b, spdata_b);
            end else begin
                ew_b = exp_wr_b.pop_front();
                check("b_sp_addr", 32'(spaddr_b), ew_b.addr);
                check("b_sp_data", 32'(spdata_b), ew_b.data);
            end
        end
        if (done_b) begin
            done_cnt_b++;
            if (exp_dn_b.size() == 0) begin
                n_checks++;
                $display("FAIL b_unexpected_done: got o_done=1, required 0");
            end else begin
                ed_b = exp_dn_b.pop_front();
                check("b_weight", 32'(weight_b), ed_b.weight);
                check("b_overflow", 32'(ovf_b), ed_b.ovf);
                check("b_done_latency", cyc - start_cyc_b, ed_b.lat);
            end
        end
    end

    task automatic start_run_a(input logic [63:0] w);
        mem_a = w;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        start_cyc_a = cyc;
    endtask

    task automatic wait_done_a();
        int base = done_cnt_a;
        for (int i = 0; i < 50 && done_cnt_a == base; i++) @(negedge clk);
        if (done_cnt_a == base) begin
            n_checks++;
            $display("FAIL a_done_timeout: got no o_done in 50 cycles, required o_done");
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        #1 rst = 1'b1;
        #1;
        check("reset_outputs_a", {rd_a, addr_a, wen_a, spaddr_a, spdata_a, weight_a, ovf_a, done_a}, 0);
        check("reset_outputs_b", {rd_b, addr_b, wen_b, spaddr_b, spdata_b, weight_b, ovf_b, done_b}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Three nonzeros fill the table exactly.
        push_wr_a(0, 1, 8'h11); push_wr_a(1, 4, 8'h22); push_wr_a(2, 7, 8'h33);
        exp_dn_a.push_back('{weight: 3, ovf: 0, lat: 6});
        start_run_a(64'h00_11_00_00_22_00_00_33);
        wait_done_a();
        check("a_weight_hold", 32'(weight_a), 3);

        // One nonzero, two pad slots.
        push_wr_a(0, 5, 8'h5A); push_wr_a(1, 0, 0); push_wr_a(2, 0, 0);
        exp_dn_a.push_back('{weight: 1, ovf: 0, lat: 5});
        start_run_a(64'h00_00_00_00_00_5A_00_00);
        wait_done_a();

        // All zero: pure padding.
        push_wr_a(0, 0, 0); push_wr_a(1, 0, 0); push_wr_a(2, 0, 0);
        exp_dn_a.push_back('{weight: 0, ovf: 0, lat: 6});
        start_run_a(64'h0);
        wait_done_a();

        // Four nonzeros into three slots: overflow, no fourth write.
        push_wr_a(0, 0, 8'h01); push_wr_a(1, 1, 8'h02); push_wr_a(2, 2, 8'h03);
        exp_dn_a.push_back('{weight: 3, ovf: 1, lat: 7});
        start_run_a(64'h01_02_03_04_00_00_00_00);
        wait_done_a();
        check("a_overflow_hold", 32'(ovf_a), 1);

        // Abort during SCAN after two writes.
        push_wr_a(0, 1, 8'h11); push_wr_a(1, 4, 8'h22);
        start_run_a(64'h00_11_00_00_22_00_00_33);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_outputs_a", {rd_a, addr_a, wen_a, spaddr_a, spdata_a, weight_a, ovf_a, done_a}, 0);
        base = done_cnt_a;
        @(negedge clk) rst = 1'b0;
        repeat (10) @(negedge clk);
        check("a_no_done_after_abort", done_cnt_a - base, 0);

        push_wr_a(0, 1, 8'h11); push_wr_a(1, 4, 8'h22); push_wr_a(2, 7, 8'h33);
        exp_dn_a.push_back('{weight: 3, ovf: 0, lat: 6});
        start_run_a(64'h00_11_00_00_22_00_00_33);
        wait_done_a();

        // Two-word vector; lane 12 lies past the 12-byte end.
        mem_b[0] = 64'h00_00_AB_00_00_00_00_00;
        mem_b[1] = 64'h00_00_00_07_09_00_00_00;
        push_wr_b(0, 2, 8'hAB); push_wr_b(1, 11, 8'h07); push_wr_b(2, 0, 0); push_wr_b(3, 0, 0);
        exp_dn_b.push_back('{weight: 2, ovf: 0, lat: 8});
        base = done_cnt_b;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        start_cyc_b = cyc;
        for (int i = 0; i < 50 && done_cnt_b == base; i++) @(negedge clk);
        if (done_cnt_b == base) begin
            n_checks++;
            $display("FAIL b_done_timeout: got no o_done in 50 cycles, required o_done");
        end
        repeat (2) @(negedge clk);

        check("a_writes_drained", exp_wr_a.size(), 0);
        check("b_writes_drained", exp_wr_b.size(), 0);
        check("a_dones_drained", exp_dn_a.size(), 0);
        check("b_dones_drained", exp_dn_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sparse_vec_pack.md
SPARSE_VEC_PACK -- requirements
Module: sparse_vec_pack

Interface
REQ-001 Parameter PARAMETER_SET, default "L3": selects the L1/L2/L3 sizes; any other value selects the test set.
REQ-002 Parameter VEC_SIZE_BYTES, default 126/193/278/8 per set: dense vector length in GF(256) bytes.
REQ-003 Parameter VEC_WEIGHT, default 79/120/150/3 per set: number of sparse slots written per run.
REQ-004 Parameter N_GF, default 8: bytes per dense word; PROC_SIZE = N_GF*8.
REQ-005 Parameter NWORDS, default ceil(VEC_SIZE_BYTES/N_GF): dense words scanned.
REQ-006 i_clk  in  1  the single clock.
REQ-007 i_rst  in  1  reset, asynchronous, active-high.
REQ-008 i_start  in  1  begin a run; sampled in IDLE only.
REQ-009 o_dense_rd  out  1  dense memory read strobe.
REQ-010 o_dense_addr  out  CLOG2(NWORDS)  dense word address.
REQ-011 i_dense  in  PROC_SIZE  dense word, valid one cycle after the address; byte lane 0 is in the MSBs.
REQ-012 o_sp_wen  out  1  sparse memory write enable.
REQ-013 o_sp_addr  out  CLOG2(VEC_WEIGHT)+1  sparse slot index.
REQ-014 o_sp_data  out  CLOG2(VEC_SIZE_BYTES)+8  {position, value}, value in bits [7:0]; this is the entry format the downstream sparse multiplier reads.
REQ-015 o_weight  out  CLOG2(VEC_WEIGHT)+1  nonzero entries written in the last run.
REQ-016 o_overflow  out  1  more than VEC_WEIGHT nonzeros were found.
REQ-017 o_done  out  1  one-cycle completion pulse.

Function
REQ-018 States are IDLE, FETCH, WAIT, SCAN, PAD and DONE.
REQ-019 IDLE->FETCH when i_start=1; at that transition o_weight, o_overflow and the word counter clear.
REQ-020 FETCH: o_dense_rd=1 and o_dense_addr=word counter, for one cycle; next state WAIT.
REQ-021 WAIT: one cycle; at its end i_dense is latched into the word register and a lane mask is built.
REQ-022 Lane mask bit k=1 iff byte k is nonzero and word*N_GF+k < VEC_SIZE_BYTES; lanes at or beyond VEC_SIZE_BYTES are ignored.
REQ-023 SCAN: each cycle the lowest set mask lane is emitted.
REQ-024 Each emitted lane gives o_sp_wen=1, o_sp_addr=o_weight, o_sp_data={word*N_GF+k, byte k}; o_weight then increments and the lane bit clears.
REQ-025 Entries are written in strictly ascending position order.
REQ-026 SCAN of an all-zero (masked) word lasts exactly one cycle with no write.
REQ-027 SCAN exit when the mask is empty: to FETCH with word+1 if word < NWORDS-1, else to PAD.
REQ-028 Per-word latency is 2+max(1,nnz) cycles.
REQ-029 Overflow: a nonzero lane found while o_weight==VEC_WEIGHT sets o_overflow=1 and is not written; the scan continues to completion.
REQ-030 PAD: while o_weight < VEC_WEIGHT, the slot at the pad counter (starting at o_weight) is written with {0,8'h00}, one per cycle; o_weight is not incremented.
REQ-031 PAD -> DONE once the slot with index VEC_WEIGHT-1 is written, or immediately if no slots remain.
REQ-032 DONE: o_done=1 for one cycle, then IDLE.
REQ-033 o_weight and o_overflow hold their values until the next accepted start.
REQ-034 i_start outside IDLE is ignored.
REQ-035 o_sp_wen and o_dense_rd are never both 1 in the same cycle.

Reset
REQ-036 i_rst=1 asynchronously forces IDLE and clears all outputs, counters, the word register and the mask.
REQ-037 Assertion mid-run aborts the run with no further writes; the next i_start runs from word 0.

Structure
REQ-038 The per-set size selections (VEC_SIZE_BYTES, VEC_WEIGHT, N_GF) and the sparse-entry field widths belong in the shared parameter package used by the sparse multiplier.
REQ-039 One sub-module, lane_prio_enc, is natural: N_GF-bit mask in -> lowest set index and valid flag out, combinational.

Verification (test set: VEC_SIZE_BYTES=8, VEC_WEIGHT=3, N_GF=8, unless stated)
REQ-040 Dense word 00_11_00_00_22_00_00_33, start -> writes {1,11},{4,22},{7,33} to slots 0..2; o_weight=3; o_overflow=0; o_done 6 cycles after start accepted.
REQ-041 Dense word 00_00_00_00_00_5A_00_00 -> slot0={5,5A}; slots 1,2={0,00}; o_weight=1.
REQ-042 All-zero dense word -> 3 pad writes of {0,00}; o_weight=0; o_done 6 cycles after start.
REQ-043 Dense word 01_02_03_04_00_00_00_00 -> slots 0..2={0,01},{1,02},{2,03}; o_overflow=1; o_weight=3; no fourth write.
REQ-044 i_rst pulsed during SCAN -> all outputs 0 immediately, no o_done; a following start with REQ-040 data reproduces the REQ-040 result.
REQ-045 Override VEC_SIZE_BYTES=12, VEC_WEIGHT=4: word1 = 00_00_00_07_09_00_00_00 -> {11,07} written; lane 12 (value 09) ignored; remaining slots padded.
